// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave shell and the RAM burst engine.
// Master drives commands and the transmit-ready; slave returns read data and status.
`timescale 1ns/1ps
interface spi_ram_burst_if #(
  parameter int MEM_WIDTH = 8
);
  logic [MEM_WIDTH+1:0] din;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 addr_err;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, addr_err
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, addr_err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port RAM command engine: set/auto-increment write and read pointers, 1-cycle reads.
// Read data held in a one-entry output slot; every command stalls while that slot is full and not draining.
`timescale 1ns/1ps
module spi_ram_burst #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_burst_if.slave bus
);

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  localparam logic [ADDR_SIZE:0]   DEPTH_W  = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [MEM_WIDTH-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 addr_err_q, addr_err_d;

  op_e                  op;
  logic [MEM_WIDTH-1:0] payload;
  logic                 rx_ready;
  logic                 accept;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic [MEM_WIDTH-1:0] rd_word;
  logic                 mem_we;
  logic                 mem_wr_en;

  // Wrap at the last real word; an out-of-range pointer keeps counting mod 2**ADDR_SIZE.
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    logic [ADDR_SIZE-1:0] n;
    if (AUTO_INC == 0) begin
      n = p;
    end else if (p == LAST_PTR) begin
      n = '0;
    end else begin
      n = p + ADDR_SIZE'(1);
    end
    return n;
  endfunction

  assign op          = op_e'(bus.din[MEM_WIDTH+1:MEM_WIDTH]);
  assign payload     = bus.din[MEM_WIDTH-1:0];
  assign rx_ready    = !tx_valid_q || bus.tx_ready;
  assign accept      = bus.rx_valid && rx_ready;
  assign wr_in_range = {1'b0, wr_ptr_q} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_ptr_q} < DEPTH_W;
  assign rd_word     = rd_in_range ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;

    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (accept) begin
      case (op)
        OP_SET_WADDR: wr_ptr_d = payload[ADDR_SIZE-1:0];
        OP_WRITE: begin
          mem_we     = wr_in_range;
          addr_err_d = !wr_in_range;
          wr_ptr_d   = ptr_next(wr_ptr_q);
        end
        OP_SET_RADDR: rd_ptr_d = payload[ADDR_SIZE-1:0];
        OP_READ: begin
          // A READ landing on the drain cycle refills the slot, so tx_valid never drops.
          dout_d     = rd_word;
          tx_valid_d = 1'b1;
          addr_err_d = !rd_in_range;
          rd_ptr_d   = ptr_next(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  // Reset must also block the array: rx_ready is high during reset and a WRITE could slip in.
  assign mem_wr_en = mem_we && rst_n;

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[wr_ptr_q] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed table-driven bench: three engines (default, MEM_DEPTH=200, AUTO_INC=0) share one command stream.
`timescale 1ns/1ps
module tb_spi_ram_burst;

  localparam logic [1:0] SW = 2'b00, WR = 2'b01, SR = 2'b10, RD = 2'b11;

  typedef struct {
    int         sel;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;
    logic       exp_rdy;
    logic       exp_tv;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic       tx_ready;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  spi_ram_burst_if #(.MEM_WIDTH(8)) if0 ();
  spi_ram_burst_if #(.MEM_WIDTH(8)) if1 ();
  spi_ram_burst_if #(.MEM_WIDTH(8)) if2 ();

  assign if0.din = din;  assign if0.rx_valid = rx_valid;  assign if0.tx_ready = tx_ready;
  assign if1.din = din;  assign if1.rx_valid = rx_valid;  assign if1.tx_ready = tx_ready;
  assign if2.din = din;  assign if2.rx_valid = rx_valid;  assign if2.tx_ready = tx_ready;

  spi_ram_burst #(.MEM_DEPTH(256), .MEM_WIDTH(8), .ADDR_SIZE(8), .AUTO_INC(1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_ram_burst #(.MEM_DEPTH(200), .MEM_WIDTH(8), .ADDR_SIZE(8), .AUTO_INC(1))
    u_dut_200 (.clk(clk), .rst_n(rst_n), .bus(if1));
  spi_ram_burst #(.MEM_DEPTH(256), .MEM_WIDTH(8), .ADDR_SIZE(8), .AUTO_INC(0))
    u_dut_ni (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic [1:0] op, input logic [7:0] pl,
                              input logic rv, input logic txr, input logic rdy,
                              input logic tv, input logic [7:0] d, input logic err);
    vec_t v;
    v.sel = sel; v.din = {op, pl}; v.rx_valid = rv; v.tx_ready = txr;
    v.exp_rdy = rdy; v.exp_tv = tv; v.exp_dout = d; v.exp_err = err;
    return v;
  endfunction

  task automatic sample(input int sel, output logic rdy, output logic tv,
                        output logic [7:0] d, output logic err);
    case (sel)
      1:       begin rdy = if1.rx_ready; tv = if1.tx_valid; d = if1.dout; err = if1.addr_err; end
      2:       begin rdy = if2.rx_ready; tv = if2.tx_valid; d = if2.dout; err = if2.addr_err; end
      default: begin rdy = if0.rx_ready; tv = if0.tx_valid; d = if0.dout; err = if0.addr_err; end
    endcase
  endtask

  // Drive on the falling edge, check rx_ready before the rising edge, registered outputs just after it.
  task automatic run_rows(input int lo, input int hi);
    logic rdy, tv, err;
    logic [7:0] d;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      din = vecs[i].din; rx_valid = vecs[i].rx_valid; tx_ready = vecs[i].tx_ready;
      #1;
      sample(vecs[i].sel, rdy, tv, d, err);
      check($sformatf("v%0d.rx_ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      sample(vecs[i].sel, rdy, tv, d, err);
      check($sformatf("v%0d.tx_valid", i), 32'(tv), 32'(vecs[i].exp_tv));
      check($sformatf("v%0d.dout", i), 32'(d), 32'(vecs[i].exp_dout));
      check($sformatf("v%0d.addr_err", i), 32'(err), 32'(vecs[i].exp_err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Burst write/read on the default engine (idx 0-8)
    vecs.push_back(mk(0, SW, 8'h10, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, WR, 8'hA5, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, WR, 8'h5A, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, WR, 8'h3C, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, SR, 8'h10, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'h5A, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'h3C, 0));
    vecs.push_back(mk(0, SW, 8'h00, 0, 1, 1, 0, 8'h3C, 0));
    // Pointer wrap at 0xFF (idx 9-15)
    vecs.push_back(mk(0, SW, 8'hFF, 1, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, WR, 8'h11, 1, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, WR, 8'h22, 1, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, SR, 8'hFF, 1, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'h11, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'h22, 0));
    vecs.push_back(mk(0, SW, 8'h00, 0, 1, 1, 0, 8'h22, 0));
    // Range check on the 200-deep engine (idx 16-21); its mem[0] holds 0x22 from the wrap writes
    vecs.push_back(mk(1, SW, 8'hC8, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(1, WR, 8'h77, 1, 1, 1, 0, 8'h22, 1));
    vecs.push_back(mk(1, SR, 8'hC8, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(1, RD, 8'h00, 1, 1, 1, 1, 8'h00, 1));
    vecs.push_back(mk(1, SR, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, RD, 8'h00, 1, 1, 1, 1, 8'h22, 0));
    // Static pointers on the AUTO_INC=0 engine (idx 22-30): all writes land on 0x05, last is 0x97
    vecs.push_back(mk(0, SW, 8'h05, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(0, WR, 8'h99, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(0, WR, 8'h98, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(0, WR, 8'h97, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(0, SR, 8'h05, 1, 1, 1, 0, 8'h22, 0));
    vecs.push_back(mk(2, RD, 8'h00, 1, 1, 1, 1, 8'h97, 0));
    vecs.push_back(mk(2, RD, 8'h00, 1, 1, 1, 1, 8'h97, 0));
    vecs.push_back(mk(2, RD, 8'h00, 1, 1, 1, 1, 8'h97, 0));
    vecs.push_back(mk(2, SW, 8'h00, 0, 1, 1, 0, 8'h97, 0));
    // Backpressure on the default engine (idx 31-38): held word, then drain plus queued READ
    vecs.push_back(mk(0, SR, 8'h10, 1, 1, 1, 0, 8'h97, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 0, 1, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, RD, 8'h00, 1, 1, 1, 1, 8'h5A, 0));
    vecs.push_back(mk(0, SW, 8'h00, 0, 1, 1, 0, 8'h5A, 0));

    rst_n = 1'b0; din = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    #1;
    check("rst.tx_valid", 32'(if0.tx_valid), 32'd0);
    check("rst.dout", 32'(if0.dout), 32'd0);
    check("rst.addr_err", 32'(if0.addr_err), 32'd0);
    check("rst.rx_ready", 32'(if0.rx_ready), 32'd1);
    check("rst.wr_ptr", 32'(u_dut.wr_ptr_q), 32'd0);
    check("rst.rd_ptr", 32'(u_dut.rd_ptr_q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_rows(0, 8);
    check("burst.rd_ptr", 32'(u_dut.rd_ptr_q), 32'h13);
    run_rows(9, 15);
    check("wrap.wr_ptr", 32'(u_dut.wr_ptr_q), 32'h01);
    run_rows(16, 21);
    run_rows(22, 30);
    check("noinc.rd_ptr", 32'(u_dut_ni.rd_ptr_q), 32'h05);
    check("noinc.wr_ptr", 32'(u_dut_ni.wr_ptr_q), 32'h05);
    run_rows(31, 38);
    check("bp.rd_ptr", 32'(u_dut.rd_ptr_q), 32'h12);

    // Reset while a word is stuck in the output slot
    @(negedge clk);
    din = {RD, 8'h00}; rx_valid = 1'b1; tx_ready = 1'b0;
    @(posedge clk);
    #1;
    check("mid.pre_tx_valid", 32'(if0.tx_valid), 32'd1);
    check("mid.pre_dout", 32'(if0.dout), 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("mid.tx_valid", 32'(if0.tx_valid), 32'd0);
    check("mid.dout", 32'(if0.dout), 32'd0);
    check("mid.rx_ready", 32'(if0.rx_ready), 32'd1);
    check("mid.wr_ptr", 32'(u_dut.wr_ptr_q), 32'd0);
    check("mid.rd_ptr", 32'(u_dut.rd_ptr_q), 32'd0);
    // A WRITE presented during reset must not reach mem[0]
    din = {WR, 8'hEE}; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    din = {RD, 8'h00}; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post.tx_valid", 32'(if0.tx_valid), 32'd1);
    check("post.dout", 32'(if0.dout), 32'h22);
    check("post.addr_err", 32'(if0.addr_err), 32'd0);
    @(negedge clk) rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post.drain", 32'(if0.tx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
